pwm_config_sequencer: RTL and testbench

Run-time configuration and soft-start controller for the interleaved PWM generator. It accepts new carrier/compare settings over a valid/ready port and holds them in a shadow register. It applies them to the generator inputs only on a carrier period boundary, and sequences the output enable with a per-period compare ramp-up on start and ramp-down on stop. It sits between the register/control interface and the interleaved PWM datapath, driving its Compare, PWMMaxCount, TriangleStepSize and DeadTimeCount inputs.

---
 rtl/pwm_config_sequencer_if.sv | 28 ++
 rtl/pwm_config_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pwm_config_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_config_sequencer_if.sv
// Configuration offer port for pwm_config_sequencer: valid/ready handshake plus
// the four carrier/compare settings held stable by the source while valid is high.
interface pwm_config_sequencer_if;
  logic        valid;
  logic        ready;
  logic [15:0] compare;
  logic [15:0] max_count;
  logic [15:0] step_size;
  logic [15:0] dead_time;

  modport master (
    output valid,
    output compare,
    output max_count,
    output step_size,
    output dead_time,
    input  ready
  );

  modport slave (
    input  valid,
    input  compare,
    input  max_count,
    input  step_size,
    input  dead_time,
    output ready
  );
endinterface

// File: rtl/pwm_config_sequencer.sv
// Shadowed run-time configuration for the interleaved PWM generator, applied on
// carrier period boundaries, with soft-start/soft-stop ramping of the compare value.
module pwm_config_sequencer #(
  parameter logic [15:0] RAMP_STEP         = 16'd16,
  parameter logic [15:0] DEFAULT_MAX_COUNT = 16'd1000
) (
  input  logic                         clk,
  input  logic                         rst,
  pwm_config_sequencer_if.slave        cfg,
  input  logic                         enable,
  input  logic                         period_start,
  output logic [15:0]                  compare,
  output logic [15:0]                  pwm_max_count,
  output logic [15:0]                  triangle_step_size,
  output logic [15:0]                  dead_time_count,
  output logic                         out_enable,
  output logic                         ramping,
  output logic                         update_ack
);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        cfg_ready_q;
  logic        cfg_ready_next;
  logic [15:0] target;
  logic [15:0] target_next;
  logic [15:0] compare_next;
  logic [15:0] max_count_next;
  logic [15:0] step_size_next;
  logic [15:0] dead_time_next;
  logic        out_enable_next;
  logic        ramping_next;
  logic        update_ack_next;

  logic [15:0] shadow_target;
  logic [15:0] shadow_max_count;
  logic [15:0] shadow_step_size;
  logic [15:0] shadow_dead_time;

  logic        accept;
  logic        apply;
  logic [16:0] ramp_sum;
  logic [15:0] ramp_up_value;
  logic [15:0] ramp_down_value;

  // The shadow is full exactly when ready is low, so accept and apply never coincide.
  assign accept    = cfg.valid && cfg_ready_q;
  assign apply     = period_start && !cfg_ready_q;
  assign cfg.ready = cfg_ready_q;

  // Ramp arithmetic uses the target as it will be after this edge's apply.
  assign ramp_sum        = {1'b0, compare} + {1'b0, RAMP_STEP};
  assign ramp_up_value   = (ramp_sum >= {1'b0, target_next}) ? target_next : ramp_sum[15:0];
  assign ramp_down_value = (compare <= RAMP_STEP) ? 16'd0 : compare - RAMP_STEP;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    cfg_ready_next  = cfg_ready_q;
    target_next     = target;
    compare_next    = compare;
    max_count_next  = pwm_max_count;
    step_size_next  = triangle_step_size;
    dead_time_next  = dead_time_count;
    out_enable_next = out_enable;
    update_ack_next = 1'b0;

    if (apply) begin
      target_next     = shadow_target;
      max_count_next  = shadow_max_count;
      step_size_next  = shadow_step_size;
      dead_time_next  = shadow_dead_time;
      cfg_ready_next  = 1'b1;
      update_ack_next = 1'b1;
    end else if (accept) begin
      cfg_ready_next = 1'b0;
    end

    unique case (state)
      OFF: begin
        compare_next = 16'd0;
        if (enable && period_start) begin
          out_enable_next = 1'b1;
          compare_next    = ramp_up_value;
          state_next      = (ramp_up_value == target_next) ? RUN : RAMP_UP;
        end
      end
      RAMP_UP: begin
        // A target below the current compare snaps down and settles in RUN.
        if (!enable) begin
          state_next = RAMP_DOWN;
        end else if (period_start) begin
          compare_next = ramp_up_value;
          if (ramp_up_value == target_next) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = RAMP_DOWN;
        end else begin
          compare_next = target_next;
        end
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_next = RAMP_UP;
        end else if (period_start) begin
          if (compare == 16'd0) begin
            out_enable_next = 1'b0;
            state_next      = OFF;
          end else begin
            compare_next = ramp_down_value;
          end
        end
      end
      default: state_next = OFF;
    endcase

    ramping_next = (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= OFF;
      cfg_ready_q        <= 1'b1;
      target             <= 16'd0;
      compare            <= 16'd0;
      pwm_max_count      <= DEFAULT_MAX_COUNT;
      triangle_step_size <= 16'd1;
      dead_time_count    <= 16'd0;
      out_enable         <= 1'b0;
      ramping            <= 1'b0;
      update_ack         <= 1'b0;
    end else begin
      state              <= state_next;
      cfg_ready_q        <= cfg_ready_next;
      target             <= target_next;
      compare            <= compare_next;
      pwm_max_count      <= max_count_next;
      triangle_step_size <= step_size_next;
      dead_time_count    <= dead_time_next;
      out_enable         <= out_enable_next;
      ramping            <= ramping_next;
      update_ack         <= update_ack_next;
    end
  end

  // NOTE: shadow data has no reset; it is only ever read while the full flag (ready low) qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_target    <= (cfg.compare > cfg.max_count) ? cfg.max_count : cfg.compare;
      shadow_max_count <= cfg.max_count;
      shadow_step_size <= (cfg.step_size == 16'd0) ? 16'd1 : cfg.step_size;
      shadow_dead_time <= cfg.dead_time;
    end
  end

endmodule

// File: tb/tb_pwm_config_sequencer.sv
// Self-checking bench for pwm_config_sequencer: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pwm_config_sequencer;

  localparam int RAMP    = 16;
  localparam int DEF_MAX = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        period_start;
  logic [15:0] compare;
  logic [15:0] pwm_max_count;
  logic [15:0] triangle_step_size;
  logic [15:0] dead_time_count;
  logic        out_enable;
  logic        ramping;
  logic        update_ack;

  pwm_config_sequencer_if cfg_if();

  pwm_config_sequencer #(
    .RAMP_STEP         (16'd16),
    .DEFAULT_MAX_COUNT (16'd1000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg                (cfg_if),
    .enable             (enable),
    .period_start       (period_start),
    .compare            (compare),
    .pwm_max_count      (pwm_max_count),
    .triangle_step_size (triangle_step_size),
    .dead_time_count    (dead_time_count),
    .out_enable         (out_enable),
    .ramping            (ramping),
    .update_ack         (update_ack)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int ack_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: what the generator should see after each clock edge.
  typedef enum int {M_OFF, M_UP, M_RUN, M_DOWN} mode_t;
  mode_t m_mode;
  int    m_cmp, m_max, m_step, m_dead, m_tgt;
  int    sh_tgt, sh_max, sh_step, sh_dead;
  bit    m_oe, m_ack, m_full, m_acc;

  function automatic void model_reset();
    m_mode = M_OFF;
    m_cmp  = 0;
    m_max  = DEF_MAX;
    m_step = 1;
    m_dead = 0;
    m_tgt  = 0;
    m_oe   = 0;
    m_ack  = 0;
    m_full = 0;
    m_acc  = 0;
  endfunction

  function automatic void model_ramp_up();
    if (m_tgt < m_cmp) begin
      m_cmp  = m_tgt;
      m_mode = M_RUN;
    end else begin
      m_cmp = (m_cmp + RAMP > m_tgt) ? m_tgt : m_cmp + RAMP;
      if (m_cmp == m_tgt) m_mode = M_RUN;
    end
  endfunction

  function automatic void model_edge(bit valid, bit ps, bit en, int c, int mx, int st, int dd);
    m_acc = valid && !m_full;
    m_ack = 0;
    if (ps && m_full) begin
      m_max  = sh_max;
      m_step = sh_step;
      m_dead = sh_dead;
      m_tgt  = sh_tgt;
      m_full = 0;
      m_ack  = 1;
    end else if (m_acc) begin
      sh_tgt  = (c > mx) ? mx : c;
      sh_max  = mx;
      sh_step = (st == 0) ? 1 : st;
      sh_dead = dd;
      m_full  = 1;
    end
    case (m_mode)
      M_OFF: begin
        if (en && ps) begin
          m_mode = M_UP;
          m_oe   = 1;
          model_ramp_up();
        end
      end
      M_UP: begin
        if (!en) m_mode = M_DOWN;
        else if (ps) model_ramp_up();
      end
      M_RUN: begin
        if (!en) m_mode = M_DOWN;
        else m_cmp = m_tgt;
      end
      default: begin
        if (en) m_mode = M_UP;
        else if (ps) begin
          if (m_cmp == 0) begin
            m_mode = M_OFF;
            m_oe   = 0;
          end else begin
            m_cmp = (m_cmp > RAMP) ? m_cmp - RAMP : 0;
          end
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    check("compare",    compare,            m_cmp);
    check("max_count",  pwm_max_count,      m_max);
    check("step_size",  triangle_step_size, m_step);
    check("dead_time",  dead_time_count,    m_dead);
    check("out_enable", out_enable,         m_oe);
    check("ramping",    ramping,            (m_mode == M_UP || m_mode == M_DOWN));
    check("update_ack", update_ack,         m_ack);
    check("cfg_ready",  cfg_if.ready,       !m_full);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cfg_if.valid, period_start, enable, int'(cfg_if.compare),
               int'(cfg_if.max_count), int'(cfg_if.step_size), int'(cfg_if.dead_time));
    #1;
    if (update_ack) ack_count++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  task automatic offer(input int c, input int mx, input int st, input int dd);
    bit done = 0;
    cfg_if.compare   = 16'(c);
    cfg_if.max_count = 16'(mx);
    cfg_if.step_size = 16'(st);
    cfg_if.dead_time = 16'(dd);
    cfg_if.valid     = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (m_acc) done = 1;
    end
    cfg_if.valid = 1'b0;
    check("offer_accepted", done, 1);
  endtask

  task automatic full_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_compare",    compare,            0);
    check("rst_max_count",  pwm_max_count,      DEF_MAX);
    check("rst_step_size",  triangle_step_size, 1);
    check("rst_dead_time",  dead_time_count,    0);
    check("rst_out_enable", out_enable,         0);
    check("rst_ramping",    ramping,            0);
    check("rst_update_ack", update_ack,         0);
    check("rst_cfg_ready",  cfg_if.ready,       1);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    enable           = 1'b0;
    period_start     = 1'b0;
    cfg_if.valid     = 1'b0;
    cfg_if.compare   = '0;
    cfg_if.max_count = '0;
    cfg_if.step_size = '0;
    cfg_if.dead_time = '0;
    full_reset();

    // Basic update path: period boundary every 50 cycles.
    ack_count = 0;
    offer(300, 1000, 2, 5);
    check("basic_ready_low", cfg_if.ready, 0);
    idle(48);
    pulse();
    check("basic_ack_pulse", update_ack, 1);
    check("basic_step",      triangle_step_size, 2);
    check("basic_dead",      dead_time_count, 5);
    check("basic_max",       pwm_max_count, 1000);
    check("basic_ready_back", cfg_if.ready, 1);
    idle(49);
    pulse();
    idle(5);
    check("basic_ack_once", ack_count, 1);

    // Soft start to 64, then full ramp down.
    offer(64, 1000, 1, 0);
    pulse();
    enable = 1'b1;
    idle(3);
    check("soft_start_idle", compare, 0);
    for (int k = 0; k < 4; k++) begin
      pulse();
      check("soft_start_cmp", compare, 16 * (k + 1));
      check("soft_start_oe", out_enable, 1);
      idle(9);
    end
    check("soft_start_run", ramping, 0);
    enable = 1'b0;
    idle(2);
    check("stop_hold", compare, 64);
    check("stop_ramping", ramping, 1);
    for (int k = 3; k >= 0; k--) begin
      pulse();
      check("stop_cmp", compare, 16 * k);
      idle(3);
    end
    check("stop_oe_still", out_enable, 1);
    pulse();
    check("stop_oe_off", out_enable, 0);

    // Stop mid-ramp at 48 with a higher target.
    offer(200, 1000, 1, 0);
    pulse();
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pulse();
      check("mid_up_cmp", compare, 16 * k);
      idle(2);
    end
    enable = 1'b0;
    idle(2);
    check("mid_hold", compare, 48);
    for (int k = 2; k >= 0; k--) begin
      pulse();
      check("mid_down_cmp", compare, 16 * k);
      idle(2);
    end
    pulse();
    check("mid_oe_off", out_enable, 0);
    check("mid_ramping_off", ramping, 0);

    // Sanitising: compare clamped to max, zero step replaced by one.
    offer(2000, 1000, 0, 7);
    pulse();
    check("san_step", triangle_step_size, 1);
    check("san_max",  pwm_max_count, 1000);
    enable = 1'b1;
    for (int k = 0; k < 70; k++) begin
      pulse();
      idle(1);
    end
    check("san_target", compare, 1000);

    // Backpressure: second offer waits for the apply of the first.
    offer(500, 1000, 3, 9);
    cfg_if.compare   = 16'd100;
    cfg_if.max_count = 16'd900;
    cfg_if.step_size = 16'd4;
    cfg_if.dead_time = 16'd11;
    cfg_if.valid     = 1'b1;
    idle(5);
    check("bp_ready_held", cfg_if.ready, 0);
    pulse();
    check("bp_first_cmp",  compare, 500);
    check("bp_first_step", triangle_step_size, 3);
    check("bp_ready_back", cfg_if.ready, 1);
    tick();
    check("bp_second_taken", cfg_if.ready, 0);
    cfg_if.valid = 1'b0;
    idle(3);
    check("bp_not_early", pwm_max_count, 1000);
    pulse();
    check("bp_second_max",  pwm_max_count, 900);
    check("bp_second_step", triangle_step_size, 4);
    check("bp_second_dead", dead_time_count, 11);
    check("bp_second_cmp",  compare, 100);

    // Async reset between edges in the middle of a ramp.
    enable = 1'b0;
    full_reset();
    offer(400, 1000, 1, 0);
    pulse();
    enable = 1'b1;
    pulse();
    pulse();
    check("ar_pre_cmp", compare, 32);
    #2 rst = 1'b1;
    #1;
    check("ar_compare", compare, 0);
    check("ar_oe",      out_enable, 0);
    check("ar_max",     pwm_max_count, DEF_MAX);
    model_reset();
    #1 rst = 1'b0;
    tick();
    check("ar_ready_after", cfg_if.ready, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      period_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (!cfg_if.valid && $urandom_range(0, 5) == 0) begin
        cfg_if.valid     = 1'b1;
        cfg_if.max_count = 16'($urandom_range(50, 1000));
        cfg_if.compare   = 16'($urandom_range(0, 1200));
        cfg_if.step_size = 16'($urandom_range(0, 3));
        cfg_if.dead_time = 16'($urandom_range(0, 63));
      end
      tick();
      if (m_acc) cfg_if.valid = 1'b0;
    end
    period_start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
